imm_extend_pipe: RTL and testbench

- Parametrised, handshaked immediate-extension stage for the MIPS datapath.
- Takes a SIZE_IN-bit immediate plus a mode, and produces a SIZE_OUT-bit operand. Modes are sign extend, zero extend, upper-load placement, or sign-extended branch offset shifted left by 2.
- Sits between decode and execute; valid/ready on both sides with a two-entry skid buffer, so back-pressure from execute never drops or duplicates an immediate.

---
 rtl/mips_pkg.sv | 13 +
 rtl/imm_extend_pipe_if.sv | 29 ++
 rtl/ext_unit.sv | 32 +++
 rtl/imm_extend_pipe.sv | 78 +++++++
 tb/tb_imm_extend_pipe.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Holds the 2-bit immediate-extension mode encoding used by both the decoder
// (which drives in_mode) and the immediate-extension stage.
package mips_pkg;

  typedef enum logic [1:0] {
    EXT_SEXT  = 2'd0,  // sign extend
    EXT_ZEXT  = 2'd1,  // zero extend
    EXT_UPPER = 2'd2,  // immediate in the top bits, zeros below
    EXT_BOFF  = 2'd3   // sign extend then shift left 2 (branch offset)
  } ext_mode_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe.
// Upstream side : in_valid, in_ready, in_imm, in_mode
// Downstream side: out_valid, out_ready, out_data, out_neg
// Modport slave is the stage itself; master is the driver/sink around it.
interface imm_extend_pipe_if #(
  parameter int SIZE_IN  = 16,
  parameter int SIZE_OUT = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [SIZE_IN-1:0]  in_imm;
  logic [1:0]          in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE_OUT-1:0] out_data;
  logic                out_neg;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg
  );

endinterface

// File: rtl/ext_unit.sv
// Combinational immediate extender.
// Ports: imm (SIZE_IN raw immediate), mode (2-bit ext_mode_e encoding),
//        result (SIZE_OUT extended operand).
module ext_unit
  import mips_pkg::*;
#(
  parameter int SIZE_IN  = 16,
  parameter int SIZE_OUT = 32
) (
  input  logic [SIZE_IN-1:0]  imm,
  input  logic [1:0]          mode,
  output logic [SIZE_OUT-1:0] result
);

  localparam int PAD = SIZE_OUT - SIZE_IN;

  logic [SIZE_OUT-1:0] sext;

  assign sext = {{PAD{imm[SIZE_IN-1]}}, imm};

  always_comb begin
    result = '0;
    case (mode)
      EXT_SEXT:  result = sext;
      EXT_ZEXT:  result = {{PAD{1'b0}}, imm};
      EXT_UPPER: result = {imm, {PAD{1'b0}}};
      EXT_BOFF:  result = {sext[SIZE_OUT-3:0], 2'b00};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Handshaked immediate-extension stage between decode and execute.
// Ports: clk, rst_n (async active-low), flush (sync, drops held entries),
//        bus (imm_extend_pipe_if.slave: in_valid/in_ready/in_imm/in_mode
//        upstream, out_valid/out_ready/out_data/out_neg downstream).
// The operand is extended on the input side; only extended results are held,
// in a main output register backed by one skid register.
module imm_extend_pipe
  import mips_pkg::*;
#(
  parameter int SIZE_IN  = 16,
  parameter int SIZE_OUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_extend_pipe_if.slave    bus
);

  if (SIZE_OUT < SIZE_IN + 2) begin : g_size_check
    $error("imm_extend_pipe: SIZE_OUT must be at least SIZE_IN + 2");
  end

  logic [SIZE_OUT-1:0] ext_result;
  logic                main_valid;
  logic [SIZE_OUT-1:0] main_data;
  logic                main_neg;
  logic                skid_valid;
  logic [SIZE_OUT-1:0] skid_data;
  logic                accept;
  logic                emit;

  ext_unit #(
    .SIZE_IN  (SIZE_IN),
    .SIZE_OUT (SIZE_OUT)
  ) u_ext (
    .imm    (bus.in_imm),
    .mode   (bus.in_mode),
    .result (ext_result)
  );

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready  = ~skid_valid;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_neg   = main_neg;

  assign accept = bus.in_valid & ~skid_valid;
  assign emit   = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_neg   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || (emit && !skid_valid)) begin
      // Main is free this edge: it takes the new input or goes empty.
      main_valid <= accept;
      if (accept) begin
        main_data <= ext_result;
        main_neg  <= ext_result[SIZE_OUT-1];
      end
    end else if (emit) begin
      // Skid is full here, so in_ready was low and nothing is accepted.
      main_data  <= skid_data;
      main_neg   <= skid_data[SIZE_OUT-1];
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_data  <= ext_result;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;

  int unsigned checks = 0;
  int unsigned errors = 0;

  imm_extend_pipe_if #(.SIZE_IN(16), .SIZE_OUT(32)) b32 ();
  imm_extend_pipe_if #(.SIZE_IN(16), .SIZE_OUT(64)) b64 ();

  imm_extend_pipe #(.SIZE_IN(16), .SIZE_OUT(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b32)
  );

  imm_extend_pipe #(.SIZE_IN(16), .SIZE_OUT(64)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic rdy);
    b32.in_valid  = v;
    b32.in_imm    = imm;
    b32.in_mode   = mode;
    b32.out_ready = rdy;
  endtask

  // Reference extension from the mode definitions, via plain integer arithmetic.
  function automatic logic [63:0] ref_ext(input int so, input logic [15:0] imm,
                                          input logic [1:0] mode);
    longint s;
    longint r;
    s = longint'($signed(imm));
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'({48'd0, imm});
      2'd2:    r = longint'({48'd0, imm}) << (so - 16);
      default: r = s * 4;
    endcase
    if (so < 64) r = r & ((64'sd1 <<< so) - 64'sd1);
    return 64'(r);
  endfunction

  logic [63:0] q[$];
  logic        fire_in;
  logic        fire_out;
  logic        fl;
  logic [15:0] rimm;
  logic [1:0]  rmode;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive32(1'b0, 16'h0, EXT_SEXT, 1'b1);
    b64.in_valid  = 1'b0;
    b64.in_imm    = '0;
    b64.in_mode   = EXT_SEXT;
    b64.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_out_data",  64'(b32.out_data),  64'd0);
    check("rst_out_neg",   64'(b32.out_neg),   64'd0);
    check("rst_in_ready",  64'(b32.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // SEXT 0x8001 with one-cycle latency
    drive32(1'b1, 16'h8001, EXT_SEXT, 1'b1);
    tick();
    check("sext_valid",    64'(b32.out_valid), 64'd1);
    check("sext_data",     64'(b32.out_data),  64'hFFFF8001);
    check("sext_neg",      64'(b32.out_neg),   64'd1);
    check("sext_in_ready", 64'(b32.in_ready),  64'd1);

    // Back-to-back modes
    drive32(1'b1, 16'h8001, EXT_ZEXT, 1'b1);
    tick();
    check("zext_data", 64'(b32.out_data), 64'h00008001);
    check("zext_neg",  64'(b32.out_neg),  64'd0);
    drive32(1'b1, 16'h1234, EXT_UPPER, 1'b1);
    tick();
    check("upper_data", 64'(b32.out_data), 64'h12340000);
    drive32(1'b1, 16'hFFFF, EXT_BOFF, 1'b1);
    tick();
    check("boff_neg_data", 64'(b32.out_data), 64'hFFFFFFFC);
    drive32(1'b1, 16'h7FFF, EXT_BOFF, 1'b1);
    tick();
    check("boff_pos_data",  64'(b32.out_data),  64'h0001FFFC);
    check("boff_pos_valid", 64'(b32.out_valid), 64'd1);
    drive32(1'b0, 16'h0, EXT_SEXT, 1'b1);
    tick();
    check("drain_valid", 64'(b32.out_valid), 64'd0);

    // Back-pressure fills the skid entry, then drains in order
    drive32(1'b1, 16'h0001, EXT_SEXT, 1'b0);
    tick();
    check("bp1_data",  64'(b32.out_data), 64'h1);
    check("bp1_ready", 64'(b32.in_ready), 64'd1);
    drive32(1'b1, 16'h0002, EXT_SEXT, 1'b0);
    tick();
    check("bp2_data",  64'(b32.out_data), 64'h1);
    check("bp2_ready", 64'(b32.in_ready), 64'd0);
    drive32(1'b0, 16'h0, EXT_SEXT, 1'b0);
    tick();
    check("bp_hold_data",  64'(b32.out_data),  64'h1);
    check("bp_hold_valid", 64'(b32.out_valid), 64'd1);
    check("bp_hold_ready", 64'(b32.in_ready),  64'd0);
    b32.out_ready = 1'b1;
    tick();
    check("bp_second_data",  64'(b32.out_data),  64'h2);
    check("bp_second_valid", 64'(b32.out_valid), 64'd1);
    check("bp_second_ready", 64'(b32.in_ready),  64'd1);
    tick();
    check("bp_empty_valid", 64'(b32.out_valid), 64'd0);

    // Flush with skid full and a simultaneous input
    drive32(1'b1, 16'h0011, EXT_SEXT, 1'b0);
    tick();
    drive32(1'b1, 16'h0022, EXT_SEXT, 1'b0);
    tick();
    check("fl_pre_ready", 64'(b32.in_ready), 64'd0);
    flush = 1'b1;
    drive32(1'b1, 16'h0033, EXT_SEXT, 1'b0);
    tick();
    check("fl_valid", 64'(b32.out_valid), 64'd0);
    check("fl_ready", 64'(b32.in_ready),  64'd1);
    flush = 1'b0;
    drive32(1'b0, 16'h0, EXT_SEXT, 1'b1);
    tick();
    check("fl_after_valid", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset between edges
    drive32(1'b1, 16'h0055, EXT_SEXT, 1'b1);
    tick();
    check("ar_pre_valid", 64'(b32.out_valid), 64'd1);
    drive32(1'b1, 16'h0056, EXT_SEXT, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(b32.out_valid), 64'd0);
    check("ar_data",  64'(b32.out_data),  64'd0);
    check("ar_neg",   64'(b32.out_neg),   64'd0);
    check("ar_ready", 64'(b32.in_ready),  64'd1);
    #1;
    rst_n = 1'b1;
    drive32(1'b1, 16'h0066, EXT_ZEXT, 1'b1);
    tick();
    check("ar_first_valid", 64'(b32.out_valid), 64'd1);
    check("ar_first_data",  64'(b32.out_data),  64'h66);
    drive32(1'b0, 16'h0, EXT_SEXT, 1'b1);
    tick();
    check("ar_drain_valid", 64'(b32.out_valid), 64'd0);

    // 64-bit build
    b64.in_valid = 1'b1;
    b64.in_imm   = 16'h8000;
    b64.in_mode  = EXT_SEXT;
    tick();
    check("w64_sext_data", b64.out_data, 64'hFFFFFFFFFFFF8000);
    check("w64_sext_neg",  64'(b64.out_neg), 64'd1);
    b64.in_mode = EXT_BOFF;
    tick();
    check("w64_boff_data", b64.out_data, 64'hFFFFFFFFFFFE0000);
    b64.in_mode = EXT_UPPER;
    b64.in_imm  = 16'h1234;
    tick();
    check("w64_upper_data", b64.out_data, 64'h1234000000000000);
    b64.in_valid = 1'b0;
    tick();

    // Randomized traffic against a two-deep FIFO model
    q.delete();
    for (int i = 0; i < 400; i++) begin
      rimm  = 16'($urandom);
      rmode = 2'($urandom_range(0, 3));
      fl    = ($urandom_range(0, 29) == 0);
      flush = fl;
      drive32(1'($urandom_range(0, 1)), rimm, rmode, ($urandom_range(0, 2) != 0));
      #1;
      check("rnd_out_valid", 64'(b32.out_valid), 64'(q.size() > 0));
      check("rnd_in_ready",  64'(b32.in_ready),  64'(q.size() < 2));
      if (q.size() > 0) begin
        check("rnd_out_data", 64'(b32.out_data), q[0]);
        check("rnd_out_neg",  64'(b32.out_neg),  64'(q[0][31]));
      end
      fire_in  = b32.in_valid && (q.size() < 2);
      fire_out = b32.out_ready && (q.size() > 0);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (fire_out) void'(q.pop_front());
        if (fire_in) q.push_back(ref_ext(32, rimm, rmode));
      end
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
